// File: rtl/ifetch_q.sv
// ---------------------------------------------------------------------------
// ifetch_q : instruction-fetch stage with internal instruction memory and a
//            prefetch queue feeding decode.
//
// A word-addressed PC walks the internal memory `mem` one word per cycle.
// Each fetched word is pushed into a QDEPTH-entry circular buffer together
// with its PC+1.
//
// Optional feature macro: IFETCH_PERF_EN
//   defined     -> perf_fetch / perf_redirect are live 32-bit wrapping counters
//   not defined -> counters are not built and both outputs read 0
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous, active-low reset
//   mode[1:0]      in   00 run, 01 hold, 10 program, 11 hold
//   w_addr         in   program-mode write word address (low bits used)
//   in_data        in   program-mode write data
//   NPC_alu        in   redirect target PC
//   sel            in   1 = redirect PC to NPC_alu (run mode only)
//   id_ready       in   decode accepts the head entry
//   IR             out  head instruction, 0 when queue empty
//   NPC            out  head entry's PC+1, 0 when queue empty
//   valid          out  queue non-empty
//   q_count        out  number of entries held
//   perf_fetch     out  pushes into the queue
//   perf_redirect  out  redirect cycles taken
//
// Handshake: the head entry {IR, NPC} transfers to decode on a rising edge
// where valid & id_ready are both high (and the stage is in run mode with no
// redirect). While valid is high and id_ready is low, IR/NPC hold steady;
// valid never drops without a transfer except on redirect, program mode or
// reset, all of which discard the queue.
// ---------------------------------------------------------------------------
module ifetch_q #(
    parameter int          XLEN       = 32,
    parameter int          IMEM_DEPTH = 1024,
    parameter int          QDEPTH     = 4,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  mode,
    input  logic [XLEN-1:0]             w_addr,
    input  logic [XLEN-1:0]             in_data,
    input  logic [XLEN-1:0]             NPC_alu,
    input  logic                        sel,
    input  logic                        id_ready,
    output logic [XLEN-1:0]             IR,
    output logic [XLEN-1:0]             NPC,
    output logic                        valid,
    output logic [$clog2(QDEPTH):0]     q_count,
    output logic [31:0]                 perf_fetch,
    output logic [31:0]                 perf_redirect
);

    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int QW = $clog2(QDEPTH);

    localparam logic [XLEN-1:0] PC_RST   = XLEN'(RESET_PC);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(1);
    localparam logic [QW:0]     CNT_FULL = (QW+1)'(QDEPTH);
    localparam logic [QW:0]     CNT_ONE  = (QW+1)'(1);
    localparam logic [QW-1:0]   PTR_ONE  = QW'(1);

    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_HOLD  = 2'b01,
        MODE_PROG  = 2'b10,
        MODE_HOLD2 = 2'b11
    } mode_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [XLEN-1:0] mem [IMEM_DEPTH];
    logic [XLEN-1:0] ir_q  [QDEPTH];
    logic [XLEN-1:0] npc_q [QDEPTH];

    logic [XLEN-1:0] pc;
    logic [QW-1:0]   wr_ptr;
    logic [QW-1:0]   rd_ptr;
    logic [QW:0]     count;

    // -----------------------------------------------------------------------
    // Control decode
    // -----------------------------------------------------------------------
    mode_e           cur_mode;
    logic            run;
    logic            prog;
    logic            redirect;
    logic            pop;
    logic            push;
    logic            flush;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] mem_rdata;

    assign cur_mode = mode_e'(mode);
    assign run      = (cur_mode == MODE_RUN);
    assign prog     = (cur_mode == MODE_PROG);

    // Redirect overrides both push and pop in the same cycle.
    assign redirect = run & sel;
    assign pop      = run & ~sel & valid & id_ready;

    // A full queue still accepts a push when the head leaves this cycle,
    // which keeps throughput at one entry per cycle under steady draining.
    assign push     = run & ~sel & ((count < CNT_FULL) | pop);

    assign flush    = redirect | prog;

    assign pc_inc    = pc + PC_STEP;
    assign mem_rdata = mem[pc[AW-1:0]];

    // Only the low index bits of the write address select a word.
    logic unused_w_addr_bits;
    assign unused_w_addr_bits = ^w_addr[XLEN-1:AW];

    // -----------------------------------------------------------------------
    // Instruction memory: no reset, written only in program mode.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (prog) begin
            mem[w_addr[AW-1:0]] <= in_data;
        end
    end

    // -----------------------------------------------------------------------
    // Program counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= PC_RST;
        end else if (prog) begin
            pc <= PC_RST;
        end else if (redirect) begin
            pc <= NPC_alu;
        end else if (push) begin
            pc <= pc_inc;
        end
    end

    // -----------------------------------------------------------------------
    // Queue pointers and occupancy
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Queue storage carries no reset; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            ir_q[wr_ptr]  <= mem_rdata;
            npc_q[wr_ptr] <= pc_inc;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign valid   = (count != '0);
    assign q_count = count;
    assign IR      = valid ? ir_q[rd_ptr]  : '0;
    assign NPC     = valid ? npc_q[rd_ptr] : '0;

    // -----------------------------------------------------------------------
    // Performance counters
    // -----------------------------------------------------------------------
`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] redirect_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (push) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (redirect) begin
                redirect_cnt <= redirect_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch    = fetch_cnt;
    assign perf_redirect = redirect_cnt;
`else
    assign perf_fetch    = '0;
    assign perf_redirect = '0;
`endif

endmodule

// File: tb/tb_ifetch_q.sv
// ---------------------------------------------------------------------------
// tb_ifetch_q : self-checking bench for ifetch_q (default parameters).
// Directed table of run/hold/redirect vectors, hand-written sequences for
// program mode and asynchronous reset, then randomized traffic compared
// against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_ifetch_q;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 1024;
    localparam int QDEPTH = 4;

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      mode     = 2'b01;
    logic [XLEN-1:0] w_addr   = '0;
    logic [XLEN-1:0] in_data  = '0;
    logic [XLEN-1:0] npc_alu  = '0;
    logic            sel      = 1'b0;
    logic            id_ready = 1'b0;

    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] npc;
    logic            valid;
    logic [2:0]      q_count;
    logic [31:0]     perf_fetch;
    logic [31:0]     perf_redirect;

    ifetch_q dut (
        .clk           (clk),
        .rst           (rst),
        .mode          (mode),
        .w_addr        (w_addr),
        .in_data       (in_data),
        .NPC_alu       (npc_alu),
        .sel           (sel),
        .id_ready      (id_ready),
        .IR            (ir),
        .NPC           (npc),
        .valid         (valid),
        .q_count       (q_count),
        .perf_fetch    (perf_fetch),
        .perf_redirect (perf_redirect)
    );

    // -----------------------------------------------------------------------
    // Reference model: queue of fetched entries, a PC and a memory image.
    // -----------------------------------------------------------------------
    typedef struct {
        logic [31:0] ir;
        logic [31:0] npc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc;
    logic [31:0] m_fetch;
    logic [31:0] m_redir;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc    = 32'd0;
        m_fetch = 32'd0;
        m_redir = 32'd0;
    endtask

    // One rising edge worth of behaviour, from the current input values.
    task automatic model_step();
        ent_t e;
        case (mode)
            2'b00: begin
                if (sel) begin
                    mq.delete();
                    m_pc = npc_alu;
                    m_redir = m_redir + 32'd1;
                end else begin
                    if (mq.size() > 0 && id_ready) mq.delete(0);
                    if (mq.size() < QDEPTH) begin
                        e.ir  = m_mem[m_pc % DEPTH];
                        e.npc = m_pc + 32'd1;
                        mq.push_back(e);
                        m_pc = m_pc + 32'd1;
                        m_fetch = m_fetch + 32'd1;
                    end
                end
            end
            2'b10: begin
                m_mem[w_addr % DEPTH] = in_data;
                mq.delete();
                m_pc = 32'd0;
            end
            default: ;
        endcase
    endtask

    task automatic check_model(input string tag);
        logic [31:0] exp_pf;
        logic [31:0] exp_pr;
`ifdef IFETCH_PERF_EN
        exp_pf = m_fetch;
        exp_pr = m_redir;
`else
        exp_pf = 32'd0;
        exp_pr = 32'd0;
`endif
        chk({tag, ".valid"},   32'(valid),   32'(mq.size() > 0));
        chk({tag, ".q_count"}, 32'(q_count), 32'(mq.size()));
        chk({tag, ".IR"},      ir,  (mq.size() > 0) ? mq[0].ir  : 32'd0);
        chk({tag, ".NPC"},     npc, (mq.size() > 0) ? mq[0].npc : 32'd0);
        chk({tag, ".perf_fetch"},    perf_fetch,    exp_pf);
        chk({tag, ".perf_redirect"}, perf_redirect, exp_pr);
    endtask

    // Drive-before-edge, model on the edge, sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        chk("reset.valid",   32'(valid),   32'd0);
        chk("reset.q_count", 32'(q_count), 32'd0);
        chk("reset.IR",      ir,  32'd0);
        chk("reset.NPC",     npc, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // -----------------------------------------------------------------------
    // Directed vector table
    // -----------------------------------------------------------------------
    typedef struct {
        logic [1:0]  mode;
        logic        sel;
        logic [31:0] npc_alu;
        logic        id_ready;
        logic        exp_valid;
        logic [2:0]  exp_count;
        logic [31:0] exp_ir;
        logic [31:0] exp_npc;
    } vec_t;

    vec_t vt[16];

    initial begin
        // mem[i] = i + 100 throughout the directed table
        vt[0]  = '{2'b00, 1'b0, 32'h0,   1'b0, 1'b1, 3'd1, 32'd100,  32'd1};
        vt[1]  = '{2'b00, 1'b0, 32'h0,   1'b0, 1'b1, 3'd2, 32'd100,  32'd1};
        vt[2]  = '{2'b00, 1'b0, 32'h0,   1'b0, 1'b1, 3'd3, 32'd100,  32'd1};
        vt[3]  = '{2'b00, 1'b0, 32'h0,   1'b0, 1'b1, 3'd4, 32'd100,  32'd1};
        vt[4]  = '{2'b00, 1'b0, 32'h0,   1'b0, 1'b1, 3'd4, 32'd100,  32'd1};
        vt[5]  = '{2'b00, 1'b0, 32'h0,   1'b1, 1'b1, 3'd4, 32'd101,  32'd2};
        vt[6]  = '{2'b00, 1'b0, 32'h0,   1'b1, 1'b1, 3'd4, 32'd102,  32'd3};
        vt[7]  = '{2'b00, 1'b0, 32'h0,   1'b1, 1'b1, 3'd4, 32'd103,  32'd4};
        vt[8]  = '{2'b00, 1'b0, 32'h0,   1'b1, 1'b1, 3'd4, 32'd104,  32'd5};
        vt[9]  = '{2'b00, 1'b1, 32'h3F0, 1'b1, 1'b0, 3'd0, 32'd0,    32'd0};
        vt[10] = '{2'b00, 1'b0, 32'h0,   1'b0, 1'b1, 3'd1, 32'd1108, 32'h3F1};
        vt[11] = '{2'b00, 1'b1, 32'h3FF, 1'b0, 1'b0, 3'd0, 32'd0,    32'd0};
        vt[12] = '{2'b00, 1'b0, 32'h0,   1'b0, 1'b1, 3'd1, 32'd1123, 32'h400};
        vt[13] = '{2'b00, 1'b0, 32'h0,   1'b1, 1'b1, 3'd1, 32'd100,  32'h401};
        vt[14] = '{2'b01, 1'b1, 32'h55,  1'b1, 1'b1, 3'd1, 32'd100,  32'h401};
        vt[15] = '{2'b11, 1'b1, 32'h77,  1'b1, 1'b1, 3'd1, 32'd100,  32'h401};
    end

    // -----------------------------------------------------------------------
    // Main sequence
    // -----------------------------------------------------------------------
    initial begin
        logic [31:0] prog_a [3];
        logic [31:0] prog_d [3];
        logic [31:0] seq_ir [4];
        logic [31:0] exp_red;
        int          r;

        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'hx;
        model_reset();
        #1;
        chk("por.valid",   32'(valid),   32'd0);
        chk("por.q_count", 32'(q_count), 32'd0);
        chk("por.IR",      ir,  32'd0);
        chk("por.NPC",     npc, 32'd0);
        do_reset();

        // Load mem[i] = i + 100 through program mode.
        mode = 2'b10;
        for (int i = 0; i < DEPTH; i++) begin
            w_addr  = 32'(i);
            in_data = 32'(i + 100);
            tick();
            if (valid !== 1'b0) chk("prog_load.valid", 32'(valid), 32'd0);
        end
        mode = 2'b01;
        do_reset();

        // Directed table.
        for (int i = 0; i < 16; i++) begin
            mode     = vt[i].mode;
            sel      = vt[i].sel;
            npc_alu  = vt[i].npc_alu;
            id_ready = vt[i].id_ready;
            tick();
            chk($sformatf("vec%0d.valid", i),   32'(valid),   32'(vt[i].exp_valid));
            chk($sformatf("vec%0d.q_count", i), 32'(q_count), 32'(vt[i].exp_count));
            chk($sformatf("vec%0d.IR", i),      ir,  vt[i].exp_ir);
            chk($sformatf("vec%0d.NPC", i),     npc, vt[i].exp_npc);
            if (i == 4) chk("stall.pc", dut.pc, 32'd4);
        end
`ifdef IFETCH_PERF_EN
        exp_red = 32'd2;
`else
        exp_red = 32'd0;
`endif
        chk("table.perf_redirect", perf_redirect, exp_red);
        sel = 1'b0;

        // Sequential stream straight out of reset.
        do_reset();
        mode = 2'b00;
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stream%0d.IR", i),      ir,  32'(100 + i));
            chk($sformatf("stream%0d.NPC", i),     npc, 32'(1 + i));
            chk($sformatf("stream%0d.q_count", i), 32'(q_count), 32'd1);
        end

        // Program mode, then run from RESET_PC.
        prog_a = '{32'd0, 32'd2, 32'd3};
        prog_d = '{32'habcdef12, 32'h12abcdef, 32'habcdef09};
        mode = 2'b10;
        for (int i = 0; i < 3; i++) begin
            w_addr  = prog_a[i];
            in_data = prog_d[i];
            tick();
            chk($sformatf("prog%0d.valid", i),   32'(valid),   32'd0);
            chk($sformatf("prog%0d.q_count", i), 32'(q_count), 32'd0);
        end
        mode = 2'b00;
        seq_ir = '{32'habcdef12, 32'd101, 32'h12abcdef, 32'habcdef09};
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("postprog%0d.IR", i),  ir,  seq_ir[i]);
            chk($sformatf("postprog%0d.NPC", i), npc, 32'(i + 1));
        end

        // Asynchronous reset between edges with three entries queued.
        do_reset();
        mode = 2'b00;
        id_ready = 1'b0;
        repeat (3) tick();
        chk("areset.pre_count", 32'(q_count), 32'd3);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("areset.valid",   32'(valid),   32'd0);
        chk("areset.q_count", 32'(q_count), 32'd0);
        chk("areset.IR",      ir,  32'd0);
        chk("areset.NPC",     npc, 32'd0);
        mode = 2'b01;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            mode     = (r < 70) ? 2'b00 : (r < 80) ? 2'b01 : (r < 92) ? 2'b10 : 2'b11;
            sel      = ($urandom_range(0, 9) == 0);
            npc_alu  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : 32'($urandom());
            id_ready = ($urandom_range(0, 3) != 0);
            w_addr   = 32'($urandom());
            in_data  = 32'($urandom());
            tick();
            check_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
